// File: rtl/mrmac_0_axis_tx_seg_packer.sv
// TX ingress packer: 128-bit AXIS frame to two 64-bit MRMAC segments with SOP/EOP/error
// marking, frame well-formedness checks and per-port statistics.
module mrmac_0_axis_tx_seg_packer #(
   parameter int unsigned MAX_BEATS = 600
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_tvalid,
   input  logic [127:0]     s_tdata,
   input  logic [15:0]      s_tkeep,
   input  logic             s_tlast,
   input  logic             s_tuser,
   output logic             s_tready,
   output logic             m_tvalid,
   output logic [1:0][63:0] m_tdata,
   output logic [1:0][10:0] m_tkeep,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic [31:0]      stat_frames,
   output logic [47:0]      stat_bytes,
   output logic [15:0]      stat_errors
);

   typedef enum logic [0:0] {StIdle, StInFrame} state_e;

   state_e           state_q, state_d;
   logic             sop;
   logic             in_accept, out_accept;
   logic [15:0]      beat_cnt_q, beat_num;
   logic             over_len, contiguous, keep_err, beat_err, frame_err, err_q;
   logic [15:0]      keep_plus;
   logic [4:0]       beat_bytes;
   logic [47:0]      frame_bytes_q;
   logic             eop_hi, eop_lo;
   logic [1:0][63:0] in_data;
   logic [1:0][10:0] in_keep;

   logic             out_valid_q, out_last_q;
   logic [1:0][63:0] out_data_q;
   logic [1:0][10:0] out_keep_q;
   logic             skid_valid_q, skid_last_q;
   logic [1:0][63:0] skid_data_q;
   logic [1:0][10:0] skid_keep_q;

   logic [31:0]      stat_frames_q;
   logic [47:0]      stat_bytes_q;
   logic [15:0]      stat_errors_q;

   assign s_tready   = !skid_valid_q && !reset;
   assign in_accept  = s_tvalid && s_tready;
   assign out_accept = out_valid_q && m_tready;

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (in_accept) begin
         unique case (state_q)
            StIdle:    state_d = s_tlast ? StIdle : StInFrame;
            StInFrame: state_d = s_tlast ? StIdle : StInFrame;
            default:   state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      sop = 1'b0;
      unique case (state_q)
         StIdle:    sop = 1'b1;
         StInFrame: sop = 1'b0;
         default:   sop = 1'b0;
      endcase
   end

   // Ordinal of the current beat within its frame, saturating.
   always_comb begin
      if (sop)                          beat_num = 16'd1;
      else if (beat_cnt_q == 16'hFFFF)  beat_num = 16'hFFFF;
      else                              beat_num = beat_cnt_q + 16'd1;
   end

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < 16; i++) beat_bytes = beat_bytes + {4'd0, s_tkeep[i]};
   end

   // Legal last-beat keep is 2^n-1: non-zero with no bit set above the lowest zero.
   assign keep_plus  = s_tkeep + 16'd1;
   assign contiguous = (s_tkeep != 16'h0000) && ((s_tkeep & keep_plus) == 16'h0000);
   assign keep_err   = s_tlast ? !contiguous : (s_tkeep != 16'hFFFF);
   assign over_len   = {16'd0, beat_num} > MAX_BEATS;
   assign beat_err   = keep_err || over_len || s_tuser;
   assign frame_err  = err_q || beat_err;

   assign eop_hi = s_tlast && (s_tkeep[15:8] != 8'h00);
   assign eop_lo = s_tlast && !eop_hi;

   assign in_data    = s_tdata;
   assign in_keep[0] = {eop_lo && frame_err, eop_lo, sop, s_tkeep[7:0]};
   assign in_keep[1] = {eop_hi && frame_err, eop_hi, 1'b0, s_tkeep[15:8]};

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt_q    <= '0;
         err_q         <= 1'b0;
         frame_bytes_q <= '0;
         stat_frames_q <= '0;
         stat_bytes_q  <= '0;
         stat_errors_q <= '0;
      end else if (in_accept) begin
         beat_cnt_q    <= s_tlast ? 16'd0 : beat_num;
         err_q         <= s_tlast ? 1'b0 : frame_err;
         frame_bytes_q <= s_tlast ? 48'd0 : frame_bytes_q + {43'd0, beat_bytes};
         if (s_tlast) begin
            stat_frames_q <= stat_frames_q + 32'd1;
            stat_bytes_q  <= stat_bytes_q + frame_bytes_q + {43'd0, beat_bytes};
            if (frame_err && stat_errors_q != 16'hFFFF) stat_errors_q <= stat_errors_q + 16'd1;
         end
      end
   end

   // Output register refills from skid first so beat order is preserved.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_keep_q  <= '0;
         skid_last_q  <= 1'b0;
      end else if (!out_valid_q || out_accept) begin
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= skid_data_q;
            out_keep_q   <= skid_keep_q;
            out_last_q   <= skid_last_q;
            skid_valid_q <= 1'b0;
         end else if (in_accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data;
            out_keep_q  <= in_keep;
            out_last_q  <= s_tlast;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (in_accept) begin
         skid_valid_q <= 1'b1;
         skid_data_q  <= in_data;
         skid_keep_q  <= in_keep;
         skid_last_q  <= s_tlast;
      end
   end

   assign m_tvalid    = out_valid_q;
   assign m_tdata     = out_data_q;
   assign m_tkeep     = out_keep_q;
   assign m_tlast     = out_last_q;
   assign stat_frames = stat_frames_q;
   assign stat_bytes  = stat_bytes_q;
   assign stat_errors = stat_errors_q;

endmodule

// File: tb/tb_mrmac_0_axis_tx_seg_packer.sv
// Directed bench for the TX segment packer: table of beats with expected segment keeps and
// statistics, plus backpressure and mid-frame reset sequences.
module tb_mrmac_0_axis_tx_seg_packer;

   logic             clk = 1'b0;
   logic             reset;
   logic             s_tvalid, s_tlast, s_tuser, s_tready, s4_tready;
   logic [127:0]     s_tdata;
   logic [15:0]      s_tkeep;
   logic             m_tvalid, m_tlast, m_tready;
   logic [1:0][63:0] m_tdata;
   logic [1:0][10:0] m_tkeep;
   logic [31:0]      stat_frames;
   logic [47:0]      stat_bytes;
   logic [15:0]      stat_errors;
   logic             m4_tvalid, m4_tlast;
   logic [1:0][63:0] m4_tdata;
   logic [1:0][10:0] m4_tkeep;
   logic [31:0]      stat4_frames;
   logic [47:0]      stat4_bytes;
   logic [15:0]      stat4_errors;

   always #5 clk = ~clk;

   mrmac_0_axis_tx_seg_packer dut (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .s_tuser(s_tuser), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
      .m_tready(m_tready),
      .stat_frames(stat_frames), .stat_bytes(stat_bytes), .stat_errors(stat_errors)
   );

   mrmac_0_axis_tx_seg_packer #(.MAX_BEATS(4)) dut4 (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .s_tuser(s_tuser), .s_tready(s4_tready),
      .m_tvalid(m4_tvalid), .m_tdata(m4_tdata), .m_tkeep(m4_tkeep), .m_tlast(m4_tlast),
      .m_tready(m_tready),
      .stat_frames(stat4_frames), .stat_bytes(stat4_bytes), .stat_errors(stat4_errors)
   );

   typedef struct {
      logic [15:0] keep;
      logic        last;
      logic        user;
      logic [10:0] ek0;
      logic [10:0] ek1;
      logic [10:0] e4k0;
      int          frames;
      int          bytes;
      int          errors;
   } vec_t;

   vec_t          vecs[$];
   logic [127:0]  exp_q[$];
   int            n_vec = 0;
   int            n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [15:0] keep, input logic last, input logic user,
                               input logic [10:0] ek0, input logic [10:0] ek1,
                               input logic [10:0] e4k0, input int fr, input int by,
                               input int er);
      vec_t v;
      v.keep = keep; v.last = last; v.user = user;
      v.ek0 = ek0; v.ek1 = ek1; v.e4k0 = e4k0;
      v.frames = fr; v.bytes = by; v.errors = er;
      return v;
   endfunction

   initial begin
      logic [127:0] d;
      logic [127:0] e;
      int           tag;
      logic         pat[4];
      logic         popped, pushed;

      // 64 B frame
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h1FF, 11'h0FF, 11'h1FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h0FF, 11'h0FF, 11'h0FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h0FF, 11'h0FF, 11'h0FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 1, 0, 11'h0FF, 11'h2FF, 11'h0FF, 1, 64, 0));
      // 65 B frame: over length for MAX_BEATS=4
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h1FF, 11'h0FF, 11'h1FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h0FF, 11'h0FF, 11'h0FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h0FF, 11'h0FF, 11'h0FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h0FF, 11'h0FF, 11'h0FF, 0, 0, 0));
      vecs.push_back(mk(16'h0001, 1, 0, 11'h201, 11'h000, 11'h601, 2, 129, 0));
      // short middle beat
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h1FF, 11'h0FF, 11'h1FF, 0, 0, 0));
      vecs.push_back(mk(16'h00FF, 0, 0, 11'h0FF, 11'h000, 11'h0FF, 0, 0, 0));
      vecs.push_back(mk(16'hFFFF, 1, 0, 11'h0FF, 11'h6FF, 11'h0FF, 3, 169, 1));
      // clean single beat after error frame
      vecs.push_back(mk(16'hFFFF, 1, 0, 11'h1FF, 11'h2FF, 11'h1FF, 4, 185, 1));
      // tuser, non-contiguous, zero keep
      vecs.push_back(mk(16'h0007, 1, 1, 11'h707, 11'h000, 11'h707, 5, 188, 2));
      vecs.push_back(mk(16'h0005, 1, 0, 11'h705, 11'h000, 11'h705, 6, 190, 3));
      vecs.push_back(mk(16'h0000, 1, 0, 11'h700, 11'h000, 11'h700, 7, 190, 4));
      // partial last beat reaching segment 1
      vecs.push_back(mk(16'hFFFF, 0, 0, 11'h1FF, 11'h0FF, 11'h1FF, 0, 0, 0));
      vecs.push_back(mk(16'h0FFF, 1, 0, 11'h0FF, 11'h20F, 11'h0FF, 8, 218, 4));

      reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      s_tuser = 1'b0; m_tready = 1'b1;
      repeat (3) step();
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tkeep", m_tkeep, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_stats", {stat_frames, stat_bytes, stat_errors}, 0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", s_tready, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         d = {32'hA000_0000 + 32'(i), ~32'(i), 32'(i) * 32'd7, 32'hC0DE_0000 | 32'(i)};
         s_tvalid = 1'b1; s_tdata = d; s_tkeep = vecs[i].keep;
         s_tlast = vecs[i].last; s_tuser = vecs[i].user;
         #1;
         check($sformatf("v%0d_ready", i), s_tready, 1);
         step();
         check($sformatf("v%0d_valid", i), m_tvalid, 1);
         check($sformatf("v%0d_data", i), m_tdata, d);
         check($sformatf("v%0d_keep", i), m_tkeep, {vecs[i].ek1, vecs[i].ek0});
         check($sformatf("v%0d_last", i), m_tlast, vecs[i].last);
         check($sformatf("v%0d_keep_mb4", i), m4_tkeep, {vecs[i].ek1, vecs[i].e4k0});
         if (vecs[i].last) begin
            check($sformatf("v%0d_frames", i), stat_frames, vecs[i].frames);
            check($sformatf("v%0d_bytes", i), stat_bytes, vecs[i].bytes);
            check($sformatf("v%0d_errors", i), stat_errors, vecs[i].errors);
         end
      end
      s_tvalid = 1'b0;
      step();
      check("idle_valid", m_tvalid, 0);

      // Back-to-back single-beat frames under ready pattern 1,0,0,1
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      tag = 0;
      for (int c = 0; c < 16; c++) begin
         s_tvalid = 1'b1; s_tdata = {96'd0, 32'hB000_0000 + 32'(tag)};
         s_tkeep = 16'hFFFF; s_tlast = 1'b1; s_tuser = 1'b0; m_tready = pat[c % 4];
         #1;
         check($sformatf("bp%0d_ready", c), s_tready, exp_q.size() < 2);
         check($sformatf("bp%0d_valid", c), m_tvalid, exp_q.size() > 0);
         popped = m_tvalid && m_tready;
         pushed = s_tvalid && s_tready;
         if (popped) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hDEAD;
            check($sformatf("bp%0d_data", c), m_tdata, e);
            check($sformatf("bp%0d_keep", c), m_tkeep, {11'h2FF, 11'h1FF});
         end
         if (pushed) begin
            exp_q.push_back({96'd0, 32'hB000_0000 + 32'(tag)});
            tag++;
         end
         step();
      end
      s_tvalid = 1'b0; m_tready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         #1;
         if (m_tvalid) begin
            e = exp_q.pop_front();
            check($sformatf("drain%0d_data", c), m_tdata, e);
            check($sformatf("drain%0d_keep", c), m_tkeep, {11'h2FF, 11'h1FF});
         end
         step();
      end
      check("bp_drained", exp_q.size(), 0);
      check("bp_count", tag, 8);
      check("bp_idle", m_tvalid, 0);

      // Reset after beat 2 of a 4-beat frame, then a fresh frame
      s_tvalid = 1'b1; s_tdata = 128'h1111; s_tkeep = 16'hFFFF; s_tlast = 1'b0;
      repeat (2) step();
      s_tvalid = 1'b0; reset = 1'b1;
      repeat (2) step();
      check("mrst_valid", m_tvalid, 0);
      check("mrst_ready", s_tready, 0);
      check("mrst_stats", {stat_frames, stat_bytes, stat_errors}, 0);
      reset = 1'b0;
      s_tvalid = 1'b1; s_tdata = 128'h2222; s_tkeep = 16'hFFFF; s_tlast = 1'b1;
      step();
      s_tvalid = 1'b0;
      check("mrst_sop_keep", m_tkeep, {11'h2FF, 11'h1FF});
      check("mrst_data", m_tdata, 128'h2222);
      check("mrst_frames", stat_frames, 1);
      check("mrst_bytes", stat_bytes, 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
